// File: rtl/alu_pkg.sv
// Shared ALU add/subtract opcode definitions and operand-prep helpers,
// used by the pipelined adder and by ALU decode.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADC  = 2'b10,
    OP_SADD = 2'b11
  } add_op_t;

  function automatic logic op_inverts_b(add_op_t op);
    return (op == OP_SUB) ? 1'b1 : 1'b0;
  endfunction

  // SUB forms a - b as a + ~b + 1; only ADC honours the external carry.
  function automatic logic op_carry_in(add_op_t op, logic cin);
    logic c;
    case (op)
      OP_SUB:  c = 1'b1;
      OP_ADC:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// One CHUNK-wide slice of the carry chain: sum/cout = a + b + cin.
// Kept behavioural so synthesis can map it onto a carry chain or DSP.
module adder_chunk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum     = total_s[WIDTH-1:0];
  assign cout    = total_s[WIDTH];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready handshake; one CHUNK resolved per stage.
// Optional feature: define ADDER_SAT_EN to make SADD a signed saturating add.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int BIT_COUNT = 8,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_COUNT-1:0] in_a,
  input  logic [BIT_COUNT-1:0] in_b,
  input  logic [1:0]           in_op,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_COUNT-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 out_zero,
  output logic                 out_neg
);

  localparam int CHUNK  = BIT_COUNT / STAGES;
  // Intermediate ranks sit between chunks; the output registers form the last rank.
  localparam int PIPE_N = (STAGES > 1) ? STAGES - 1 : 1;
`ifdef ADDER_SAT_EN
  localparam logic [BIT_COUNT-1:0] SAT_MAX = {1'b0, {(BIT_COUNT-1){1'b1}}};
  localparam logic [BIT_COUNT-1:0] SAT_MIN = {1'b1, {(BIT_COUNT-1){1'b0}}};
`endif

  add_op_t              op_s;
  logic                 adv_s;

  logic [STAGES-1:0]    stg_v_s;
  logic [STAGES-1:0]    stg_c_s;
  logic [BIT_COUNT-1:0] stg_a_s   [STAGES];
  logic [BIT_COUNT-1:0] stg_bp_s  [STAGES];
  logic [BIT_COUNT-1:0] stg_sum_s [STAGES];
  logic [BIT_COUNT-1:0] res_sum_s [STAGES];
  logic [BIT_COUNT-1:0] chunk_sum_s;
  logic [STAGES-1:0]    chunk_cout_s;

  logic [BIT_COUNT-1:0] raw_sum_s;
  logic [BIT_COUNT-1:0] fin_sum_s;
  logic                 a_msb_s;
  logic                 bp_msb_s;
  logic                 ovf_s;

  logic [PIPE_N-1:0]    pipe_v_r;
  logic [PIPE_N-1:0]    pipe_c_r;
  logic [BIT_COUNT-1:0] pipe_a_r   [PIPE_N];
  logic [BIT_COUNT-1:0] pipe_bp_r  [PIPE_N];
  logic [BIT_COUNT-1:0] pipe_sum_r [PIPE_N];

`ifdef ADDER_SAT_EN
  logic [STAGES-1:0]    stg_sat_s;
  logic [PIPE_N-1:0]    pipe_sat_r;
`endif

  logic                 out_valid_r;
  logic [BIT_COUNT-1:0] out_sum_r;
  logic                 out_cout_r;
  logic                 out_ovf_r;
  logic                 out_zero_r;
  logic                 out_neg_r;

  assign op_s     = add_op_t'(in_op);
  assign adv_s    = ~out_valid_r | out_ready;
  assign in_ready = adv_s;

  // Stage inputs: stage 0 takes prepared operands, later stages read the previous rank.
  always_comb begin
    stg_v_s = {STAGES{1'b0}};
    stg_c_s = {STAGES{1'b0}};
`ifdef ADDER_SAT_EN
    stg_sat_s = {STAGES{1'b0}};
    stg_sat_s[0] = (op_s == OP_SADD) ? 1'b1 : 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      stg_a_s[k]   = {BIT_COUNT{1'b0}};
      stg_bp_s[k]  = {BIT_COUNT{1'b0}};
      stg_sum_s[k] = {BIT_COUNT{1'b0}};
    end
    stg_v_s[0]  = in_valid;
    stg_a_s[0]  = in_a;
    stg_bp_s[0] = op_inverts_b(op_s) ? ~in_b : in_b;
    stg_c_s[0]  = op_carry_in(op_s, in_cin);
    for (int k = 1; k < STAGES; k++) begin
      stg_v_s[k]   = pipe_v_r[k-1];
      stg_a_s[k]   = pipe_a_r[k-1];
      stg_bp_s[k]  = pipe_bp_r[k-1];
      stg_sum_s[k] = pipe_sum_r[k-1];
      stg_c_s[k]   = pipe_c_r[k-1];
`ifdef ADDER_SAT_EN
      stg_sat_s[k] = pipe_sat_r[k-1];
`endif
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    adder_chunk #(.WIDTH(CHUNK)) u_chunk (
      .a    (stg_a_s[g][g*CHUNK +: CHUNK]),
      .b    (stg_bp_s[g][g*CHUNK +: CHUNK]),
      .cin  (stg_c_s[g]),
      .sum  (chunk_sum_s[g*CHUNK +: CHUNK]),
      .cout (chunk_cout_s[g])
    );
  end

  // Merge each resolved chunk into its skewed partial sum; derive final result and overflow.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res_sum_s[k] = stg_sum_s[k];
      res_sum_s[k][k*CHUNK +: CHUNK] = chunk_sum_s[k*CHUNK +: CHUNK];
    end
    raw_sum_s = res_sum_s[STAGES-1];
    a_msb_s   = stg_a_s[STAGES-1][BIT_COUNT-1];
    bp_msb_s  = stg_bp_s[STAGES-1][BIT_COUNT-1];
    ovf_s     = (a_msb_s == bp_msb_s) && (raw_sum_s[BIT_COUNT-1] != a_msb_s);
`ifdef ADDER_SAT_EN
    // Both operands share a sign on overflow, so a's sign picks the clamp direction.
    if (stg_sat_s[STAGES-1] && ovf_s) begin
      fin_sum_s = a_msb_s ? SAT_MIN : SAT_MAX;
    end else begin
      fin_sum_s = raw_sum_s;
    end
`else
    fin_sum_s = raw_sum_s;
`endif
  end

  // Pipeline ranks and output registers; the whole pipe moves or holds together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v_r <= {PIPE_N{1'b0}};
      pipe_c_r <= {PIPE_N{1'b0}};
`ifdef ADDER_SAT_EN
      pipe_sat_r <= {PIPE_N{1'b0}};
`endif
      for (int k = 0; k < PIPE_N; k++) begin
        pipe_a_r[k]   <= {BIT_COUNT{1'b0}};
        pipe_bp_r[k]  <= {BIT_COUNT{1'b0}};
        pipe_sum_r[k] <= {BIT_COUNT{1'b0}};
      end
      out_valid_r <= 1'b0;
      out_sum_r   <= {BIT_COUNT{1'b0}};
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_zero_r  <= 1'b0;
      out_neg_r   <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pipe_v_r[k]   <= stg_v_s[k];
        pipe_a_r[k]   <= stg_a_s[k];
        pipe_bp_r[k]  <= stg_bp_s[k];
        pipe_sum_r[k] <= res_sum_s[k];
        pipe_c_r[k]   <= chunk_cout_s[k];
`ifdef ADDER_SAT_EN
        pipe_sat_r[k] <= stg_sat_s[k];
`endif
      end
      out_valid_r <= stg_v_s[STAGES-1];
      out_sum_r   <= fin_sum_s;
      out_cout_r  <= chunk_cout_s[STAGES-1];
      out_ovf_r   <= ovf_s;
      out_zero_r  <= (fin_sum_s == {BIT_COUNT{1'b0}}) ? 1'b1 : 1'b0;
      out_neg_r   <= fin_sum_s[BIT_COUNT-1];
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;
  assign out_zero  = out_zero_r;
  assign out_neg   = out_neg_r;

endmodule
